// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Turns a byte stream from a UART receiver into register writes. A frame is
// five bytes: SYNC_BYTE, ADDR, DATA_H, DATA_L, CHK, where
// CHK = ADDR ^ DATA_H ^ DATA_L. A good frame produces one wr_en strobe. A bad
// checksum produces one err_chk pulse. If the gap between bytes inside a frame
// is too long, the module produces one err_tout pulse and drops the frame.
//
// Parameters
//   TIMEOUT_CLKS : maximum clk cycles allowed between consecutive frame bytes
//   SYNC_BYTE    : frame start marker
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   rx_dv    in   single-cycle byte-valid strobe
//   rx_byte  in   [7:0] received byte, valid with rx_dv
//   wr_en    out  single-cycle register-write strobe
//   wr_addr  out  [7:0] register address, holds last committed value
//   wr_data  out  [15:0] register data, holds last committed value
//   err_chk  out  single-cycle checksum-error pulse
//   err_tout out  single-cycle inter-byte timeout pulse
//   busy     out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CLKS = 8680,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        err_chk,
    output logic        err_tout,
    output logic        busy
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATH,
        S_DATL,
        S_CHK
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic             wr_en_d, err_chk_d, err_tout_d;
    logic [7:0]       wr_addr_d;
    logic [15:0]      wr_data_d;

    assign busy = (state != S_IDLE);

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state;
        cnt_d      = cnt;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        err_chk_d  = 1'b0;
        err_tout_d = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;

        if (rx_dv) begin
            // A byte always wins over the timeout, even at terminal count.
            cnt_d = '0;
            unique case (state)
                S_IDLE: begin
                    // Only the sync byte opens a frame. Other bytes are dropped
                    // without any error.
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_d  = rx_byte;
                    state_d = S_DATH;
                end
                S_DATH: begin
                    data_d[15:8] = rx_byte;
                    state_d      = S_DATL;
                end
                S_DATL: begin
                    data_d[7:0] = rx_byte;
                    state_d     = S_CHK;
                end
                S_CHK: begin
                    if (rx_byte == (addr_q ^ data_q[15:8] ^ data_q[7:0])) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_q;
                    end else begin
                        err_chk_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (cnt == CNT_TERM) begin
                err_tout_d = 1'b1;
                state_d    = S_IDLE;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State and output registers. All outputs are registered, so each strobe
    // appears one clk after the rx_dv that caused it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge value of every other register.
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_en    <= 1'b0;
            err_chk  <= 1'b0;
            err_tout <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_en    <= wr_en_d;
            err_chk  <= err_chk_d;
            err_tout <= err_tout_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
        end
    end

endmodule
